// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types and constants
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; stray low bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry FIFO of fetch entries with flush
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Flush drops everything by snapping the read pointer onto the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and fetch queue front end for decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  fetch_entry_t     head;
  fetch_entry_t     wdata;

  // Redirect wins over both queue ports; a pop frees the slot the push needs.
  assign pop   = id_valid & id_ready & ~redirect_valid;
  assign push  = ~redirect_valid & ((count < CNT_W'(DEPTH)) | pop);
  assign wdata = '{pc: pc_q, instr: instr_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc_q <= RESET_PC;
    else if (redirect_valid)
      pc_q <= align_pc(redirect_pc);
    else if (push)
      pc_q <= pc_q + 32'd4;
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign pc_out      = pc_q;
  assign id_valid    = (count != '0);
  assign id_instr    = id_valid ? head.instr : NOP_INSTR;
  assign id_pc       = id_valid ? head.pc : 32'h0;
  assign id_pc_plus4 = id_pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_a, rdy_a, rv_a;
  logic [31:0] rpc_a, pcout_a, instr_a, idinstr_a, idpc_a, pc4_a;
  logic        v_a;
  logic        rst_b, rdy_b, rv_b;
  logic [31:0] rpc_b, pcout_b, instr_b, idinstr_b, idpc_b, pc4_b;
  logic        v_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[13:2], 5'd0, 3'b000, 5'd0, 7'h13};
  endfunction

  assign instr_a = mem_word(pcout_a);
  assign instr_b = mem_word(pcout_b);

  fetch_unit dut_a (
    .clk(clk), .reset(rst_a), .pc_out(pcout_a), .instr_in(instr_a),
    .redirect_valid(rv_a), .redirect_pc(rpc_a), .id_ready(rdy_a),
    .id_valid(v_a), .id_instr(idinstr_a), .id_pc(idpc_a), .id_pc_plus4(pc4_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .reset(rst_b), .pc_out(pcout_b), .instr_in(instr_b),
    .redirect_valid(rv_b), .redirect_pc(rpc_b), .id_ready(rdy_b),
    .id_valid(v_b), .id_instr(idinstr_b), .id_pc(idpc_b), .id_pc_plus4(pc4_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // An accepted instruction with nothing queued compares against an unaligned sentinel.
  task automatic sb_compare();
    logic [31:0] e;
    if (v_a && rdy_a && !rv_a) begin
      if (exp_a.size() != 0) e = exp_a.pop_front();
      else e = 32'hDEAD_BEEF;
      check("a_id_pc", idpc_a, e);
      check("a_id_instr", idinstr_a, mem_word(e));
      check("a_id_pc_plus4", pc4_a, e + 32'd4);
    end
    if (v_b && rdy_b && !rv_b) begin
      if (exp_b.size() != 0) e = exp_b.pop_front();
      else e = 32'hDEAD_BEEF;
      check("b_id_pc", idpc_b, e);
      check("b_id_instr", idinstr_b, mem_word(e));
      check("b_id_pc_plus4", pc4_b, e + 32'd4);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rdy_a = 1'b0; rv_a = 1'b0; rpc_a = '0;
    rst_b = 1'b1; rdy_b = 1'b1; rv_b = 1'b0; rpc_b = '0;
    #2;
    check("rst_id_valid", {31'd0, v_a}, 32'd0);
    check("rst_id_instr", idinstr_a, 32'h0000_0013);
    check("rst_id_pc", idpc_a, 32'd0);
    check("rst_id_pc_plus4", pc4_a, 32'd4);
    check("rst_pc_out", pcout_a, 32'd0);
    check("rst_pc_out_b", pcout_b, 32'hFFFF_FFF8);
    @(posedge clk); #1;

    // Streaming from reset release: 0,4,8 back to back
    rst_a = 1'b0; rdy_a = 1'b1;
    exp_a.push_back(32'h0); exp_a.push_back(32'h4); exp_a.push_back(32'h8);
    repeat (4) tick();
    check("stream_drained", 32'(exp_a.size()), 32'd0);
    rst_a = 1'b1;
    #1;
    check("async_id_valid", {31'd0, v_a}, 32'd0);
    check("async_pc_out", pcout_a, 32'd0);

    // Stall from reset until full, then drain two entries
    @(posedge clk); #1;
    rst_a = 1'b0; rdy_a = 1'b0;
    repeat (5) tick();
    check("stall_pc_out", pcout_a, 32'h8);
    check("stall_id_pc", idpc_a, 32'h0);
    check("stall_id_valid", {31'd0, v_a}, 32'd1);
    exp_a.push_back(32'h0); exp_a.push_back(32'h4);
    rdy_a = 1'b1;
    repeat (2) tick();
    check("pre_redirect_head", idpc_a, 32'h8);

    // Redirect to 0x40 while 0x8/0xC are queued
    rv_a = 1'b1; rpc_a = 32'h40;
    exp_a.push_back(32'h40);
    tick();
    rv_a = 1'b0;
    check("redir_id_valid", {31'd0, v_a}, 32'd0);
    check("redir_pc_out", pcout_a, 32'h40);
    repeat (2) tick();

    // Misaligned redirect target
    rv_a = 1'b1; rpc_a = 32'h43;
    exp_a.push_back(32'h40);
    tick();
    rv_a = 1'b0;
    check("misalign_pc_out", pcout_a, 32'h40);
    check("misalign_id_valid", {31'd0, v_a}, 32'd0);
    repeat (2) tick();

    // Fill to full, confirm PC freezes, then release without gaps
    rdy_a = 1'b0;
    repeat (2) tick();
    check("full_pc_out", pcout_a, 32'h4C);
    check("full_id_pc", idpc_a, 32'h44);
    tick();
    check("full_pc_frozen", pcout_a, 32'h4C);
    exp_a.push_back(32'h44); exp_a.push_back(32'h48);
    exp_a.push_back(32'h4C); exp_a.push_back(32'h50);
    rdy_a = 1'b1;
    repeat (4) tick();
    rdy_a = 1'b0;
    check("refull_head", idpc_a, 32'h54);

    // Redirect while full and stalled
    rv_a = 1'b1; rpc_a = 32'h100;
    exp_a.push_back(32'h100);
    tick();
    rv_a = 1'b0;
    check("full_redir_id_valid", {31'd0, v_a}, 32'd0);
    check("full_redir_pc_out", pcout_a, 32'h100);
    rdy_a = 1'b1;
    repeat (2) tick();
    rdy_a = 1'b0;
    check("a_sb_drained", 32'(exp_a.size()), 32'd0);

    // PC wrap with RESET_PC near the top of the address space
    rst_b = 1'b0;
    exp_b.push_back(32'hFFFF_FFF8); exp_b.push_back(32'hFFFF_FFFC); exp_b.push_back(32'h0);
    repeat (4) tick();
    check("b_sb_drained", 32'(exp_b.size()), 32'd0);
    #2;
    rst_b = 1'b1;
    #1;
    check("b_async_id_valid", {31'd0, v_b}, 32'd0);
    check("b_async_pc_out", pcout_b, 32'hFFFF_FFF8);
    check("b_async_id_pc", idpc_b, 32'd0);
    check("b_async_id_instr", idinstr_b, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end of the 5-stage RISC-V core. It owns the PC, drives the combinational instruction memory, and buffers fetched instructions in a small queue. The queue feeds the decode stage through a valid/ready handshake. Branch/jump redirects from EX flush the queue and reload the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
DEPTH, 2, fetch-queue entries; power of two, minimum 2.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
pc_out  output  32  fetch address to instr_mem; instr_mem returns data combinationally in the same cycle.
instr_in  input  32  instruction word from instr_mem for pc_out.
redirect_valid  input  1  taken branch/jump from EX, single-cycle pulse.
redirect_pc  input  32  redirect target address.
id_ready  input  1  decode can accept an instruction this cycle (low means stall).
id_valid  output  1  the head of the queue holds a valid instruction.
id_instr  output  32  head instruction; reads 32'h0000_0013 (NOP) when id_valid=0.
id_pc  output  32  PC of the head instruction; reads 0 when id_valid=0.
id_pc_plus4  output  32  id_pc + 4, modulo 2^32.

Behaviour:
- State: pc_q[31:0], queue of DEPTH entries {pc, instr}, rd_ptr/wr_ptr (log2 DEPTH bits), count (0..DEPTH).
- Reset (async, asserting): pc_q=RESET_PC, count=0, rd_ptr=wr_ptr=0. Outputs: id_valid=0, id_instr=NOP, id_pc=0, pc_out=RESET_PC. Reset asserted mid-operation discards all queued entries immediately.
- pc_out = pc_q at all times (combinational from the register).
- pop = id_valid & id_ready & ~redirect_valid.
- push = ~redirect_valid & (count < DEPTH | pop).
- push: write {pc_q, instr_in} at wr_ptr, wr_ptr++, pc_q <= pc_q + 4. PC wraps from 32'hFFFF_FFFC to 0.
- No push (queue full with no pop): pc_q holds, and instr_mem is re-read the next cycle.
- pop: rd_ptr++. Both pointers wrap modulo DEPTH.
- count update: count+1 on push only, count-1 on pop only, unchanged when push and pop occur together.
- Redirect has priority over push and pop. On redirect: count <= 0, rd_ptr <= wr_ptr, pc_q <= {redirect_pc[31:2], 2'b00} (low bits are silently cleared), and no entry is written that cycle. The redirect target is fetched the following cycle.
- id_valid = (count != 0). id_instr, id_pc and id_pc_plus4 come combinationally from the head entry and are stable while id_valid=1 and id_ready=0.
- Latency: an instruction fetched in cycle N is presented on id_* in cycle N+1 at the earliest. After reset deassertion, id_valid rises one cycle after the first clock edge.
- Redirect penalty: two cycles with id_valid=0 (the redirect cycle's edge, then the refetch).
- Steady state with id_ready held at 1: one instruction per cycle, and count stays at 1.
- Full queue with id_ready=0: pc_q frozen, no instructions lost or duplicated.
- Redirect while count=DEPTH with id_ready=0: flush still occurs, and nothing is popped.

Decomposition:
- Shared package (alongside opcodes/control types):
  - constant NOP_INSTR = 32'h0000_0013.
  - struct fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- One sub-module, fetch_queue: a generic DEPTH-entry synchronous FIFO of fetch_entry_t with push/pop/flush and count. It uses the same async active-high reset.
- fetch_unit keeps the PC logic and the redirect priority.

Test Plan:
- Reset release, id_ready=1, memory holding addi at 0x0/0x4/0x8 -> id_pc sequence 0x0, 0x4, 0x8 on consecutive cycles starting one cycle after release; id_pc_plus4 = id_pc+4.
- Hold id_ready=0 for 5 cycles after reset -> count saturates at 2, pc_out freezes at 0x8, id_pc stays 0x0. On release -> 0x0, 0x4, 0x8, 0xC with no gaps or duplicates.
- redirect_valid pulse with redirect_pc=0x40 while the queue holds 0x8/0xC -> next cycle id_valid=0 and pc_out=0x40; the following cycle id_pc=0x40; 0x8/0xC never popped.
- redirect_pc=0x43 -> fetch from 0x40.
- Redirect while full and stalled (count=2, id_ready=0) -> queue flushed, no pop reported, id_pc=target two cycles later.
- RESET_PC=32'hFFFF_FFF8 -> id_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting reset mid-run returns id_valid=0 and pc_out=RESET_PC without waiting for a clock edge.
